// File: rtl/seq_array_multiplier.sv
// Iterative shift-add multiplier: one partial product per clock, valid/ready on both sides.
// Optional two's complement mode when SIGNED_MULT_EN is defined (adds the in_signed port).
module seq_array_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
`ifdef SIGNED_MULT_EN
    input  logic                 in_signed,
`endif
    output logic                 busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   a_q;
    logic [WIDTH-1:0] b_q;
    logic [PW-1:0]   p_q;
    logic [CW-1:0]   cnt_q;
`ifdef SIGNED_MULT_EN
    logic            signed_q;
`endif

    logic            last_iter_c;
    logic [PW-1:0]   a_ext_c;
    logic [PW-1:0]   p_d;

    assign last_iter_c = (cnt_q == CW'(WIDTH - 1));

    // Operand extension at acceptance and the per-iteration accumulate step.
    always_comb begin
        a_ext_c = {{WIDTH{1'b0}}, in_a};
        p_d     = p_q;
`ifdef SIGNED_MULT_EN
        if (in_signed) begin
            a_ext_c = {{WIDTH{in_a[WIDTH-1]}}, in_a};
        end
`endif
        if (b_q[0]) begin
            p_d = p_q + a_q;
`ifdef SIGNED_MULT_EN
            // Multiplier sign bit carries negative weight in the last iteration.
            if (signed_q && last_iter_c) begin
                p_d = p_q - a_q;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_p     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
`ifdef SIGNED_MULT_EN
            signed_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q      <= a_ext_c;
                        b_q      <= in_b;
                        p_q      <= '0;
                        cnt_q    <= '0;
`ifdef SIGNED_MULT_EN
                        signed_q <= in_signed;
`endif
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_q  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    p_q   <= p_d;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_iter_c) begin
                        out_p     <= p_d;
                        out_valid <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Acceptance is deferred one cycle after consumption.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Bench for seq_array_multiplier: a WIDTH=8 and a WIDTH=4 instance, scoreboard of expected products.
// Signed scenarios run only when SIGNED_MULT_EN is defined.
module tb_seq_array_multiplier;

    logic        clk;
    logic        rst_n;

    logic        v8, rdy8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        v4, rdy4, ov4, or4, busy4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;
`ifdef SIGNED_MULT_EN
    logic        s4;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] sb8[$];
    logic [7:0]  sb4[$];

    seq_array_multiplier #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v8),
        .in_ready  (rdy8),
        .in_a      (a8),
        .in_b      (b8),
        .out_valid (ov8),
        .out_ready (or8),
        .out_p     (p8),
`ifdef SIGNED_MULT_EN
        .in_signed (1'b0),
`endif
        .busy      (busy8)
    );

    seq_array_multiplier #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v4),
        .in_ready  (rdy4),
        .in_a      (a4),
        .in_b      (b4),
        .out_valid (ov4),
        .out_ready (or4),
        .out_p     (p4),
`ifdef SIGNED_MULT_EN
        .in_signed (s4),
`endif
        .busy      (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp4(input logic s, input logic [3:0] a, input logic [3:0] b);
        int sa;
        int sb;
        sa = (s && a[3]) ? int'(a) - 16 : int'(a);
        sb = (s && b[3]) ? int'(b) - 16 : int'(b);
        return 8'(sa * sb);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (rdy8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0 || p8 !== 16'h0) begin
            errors++;
            $display("FAIL reset8: rdy=%b ov=%b busy=%b p=%h required 1 0 0 0000", rdy8, ov8, busy8, p8);
        end
        checks++;
        if (rdy4 !== 1'b1 || ov4 !== 1'b0 || busy4 !== 1'b0 || p4 !== 8'h0) begin
            errors++;
            $display("FAIL reset4: rdy=%b ov=%b busy=%b p=%h required 1 0 0 00", rdy4, ov4, busy4, p4);
        end
        rst_n = 1'b1;
        tick();
    endtask

    // One full transaction on the WIDTH=8 instance; consumption checked when out_ready is high.
    task automatic run8(input logic [7:0] a, input logic [7:0] b);
        int lat;
        logic [15:0] expv;
        checks++;
        if (rdy8 !== 1'b1) begin
            errors++;
            $display("FAIL run8_ready: in_ready=%b required 1", rdy8);
        end
        v8 = 1'b1;
        a8 = a;
        b8 = b;
        sb8.push_back(16'(int'(a) * int'(b)));
        tick();
        v8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        checks++;
        if (busy8 !== 1'b1 || rdy8 !== 1'b0) begin
            errors++;
            $display("FAIL run8_accept: busy=%b in_ready=%b required 1 0", busy8, rdy8);
        end
        lat = 0;
        while (ov8 !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL run8_latency: got %0d cycles required 8", lat);
        end
        expv = sb8.pop_front();
        checks++;
        if (p8 !== expv) begin
            errors++;
            $display("FAIL run8_product a=%0d b=%0d: got %0d required %0d", a, b, p8, expv);
        end
        if (or8) begin
            tick();
            checks++;
            if (ov8 !== 1'b0 || rdy8 !== 1'b1 || busy8 !== 1'b0) begin
                errors++;
                $display("FAIL run8_consume: ov=%b rdy=%b busy=%b required 0 1 0", ov8, rdy8, busy8);
            end
        end
    endtask

    task automatic run4(input logic s, input logic [3:0] a, input logic [3:0] b);
        int lat;
        logic [7:0] expv;
`ifdef SIGNED_MULT_EN
        s4 = s;
`endif
        v4 = 1'b1;
        a4 = a;
        b4 = b;
        sb4.push_back(exp4(s, a, b));
        tick();
        v4 = 1'b0;
        a4 = 4'($urandom);
        b4 = 4'($urandom);
        lat = 0;
        while (ov4 !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL run4_latency: got %0d cycles required 4", lat);
        end
        expv = sb4.pop_front();
        checks++;
        if (p4 !== expv) begin
            errors++;
            $display("FAIL run4_product s=%b a=%h b=%h: got %h required %h", s, a, b, p4, expv);
        end
        tick();
        checks++;
        if (ov4 !== 1'b0 || rdy4 !== 1'b1) begin
            errors++;
            $display("FAIL run4_consume: ov=%b rdy=%b required 0 1", ov4, rdy4);
        end
    endtask

    task automatic test_basic();
        or8 = 1'b1;
        or4 = 1'b1;
        run4(1'b0, 4'hF, 4'hF);
        run8(8'd200, 8'd3);
        run8(8'd0, 8'd255);
        run8(8'd255, 8'd255);
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        or8 = 1'b0;
        run8(8'd37, 8'd11);
        held = p8;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                v8 = 1'b1;
                a8 = 8'd1;
                b8 = 8'd1;
            end
            tick();
            checks++;
            if (ov8 !== 1'b1 || p8 !== 16'd407 || rdy8 !== 1'b0 || p8 !== held) begin
                errors++;
                $display("FAIL hold_%0d: ov=%b p=%0d rdy=%b required 1 407 0", i, ov8, p8, rdy8);
            end
        end
        v8 = 1'b0;
        or8 = 1'b1;
        tick();
        checks++;
        if (ov8 !== 1'b0 || rdy8 !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: ov=%b rdy=%b required 0 1", ov8, rdy8);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (ov8 !== 1'b0 || busy8 !== 1'b0) begin
                errors++;
                $display("FAIL hold_single_transfer_%0d: ov=%b busy=%b required 0 0", i, ov8, busy8);
            end
        end
    endtask

    task automatic test_reset_mid();
        or8 = 1'b1;
        v8 = 1'b1;
        a8 = 8'd255;
        b8 = 8'd255;
        tick();
        v8 = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (ov8 !== 1'b0 || busy8 !== 1'b0 || rdy8 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: ov=%b busy=%b rdy=%b required 0 0 1", ov8, busy8, rdy8);
        end
        tick();
        run8(8'd2, 8'd3);
    endtask

    task automatic test_signed();
        or4 = 1'b1;
`ifdef SIGNED_MULT_EN
        run4(1'b1, 4'hD, 4'h5);
        run4(1'b1, 4'h8, 4'h8);
        run4(1'b1, 4'h7, 4'h9);
`endif
        run4(1'b0, 4'h8, 4'h8);
        run4(1'b0, 4'hD, 4'h5);
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        int n_acc = 0;
        int last = -1;
        logic acc;
        logic [3:0] ea;
        logic [3:0] eb;
        logic [7:0] expv;
        or4 = 1'b1;
`ifdef SIGNED_MULT_EN
        s4 = 1'b0;
`endif
        a4 = 4'($urandom);
        b4 = 4'($urandom);
        v4 = 1'b1;
        while ((n_acc < 5 || sb4.size() > 0) && cyc < 200) begin
            acc = v4 && rdy4;
            ea = a4;
            eb = b4;
            tick();
            cyc++;
            if (acc) begin
                sb4.push_back(exp4(1'b0, ea, eb));
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 6) begin
                        errors++;
                        $display("FAIL b2b_interval: got %0d cycles required 6", cyc - last);
                    end
                end
                last = cyc;
                n_acc++;
                if (n_acc == 5) begin
                    v4 = 1'b0;
                end else begin
                    a4 = 4'($urandom);
                    b4 = 4'($urandom);
                end
            end
            if (ov4 === 1'b1) begin
                checks++;
                if (sb4.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected_output: got %h required none", p4);
                end else begin
                    expv = sb4.pop_front();
                    if (p4 !== expv) begin
                        errors++;
                        $display("FAIL b2b_product: got %h required %h", p4, expv);
                    end
                end
            end
        end
        v4 = 1'b0;
        checks++;
        if (n_acc != 5 || sb4.size() != 0) begin
            errors++;
            $display("FAIL b2b_complete: accepts=%0d pending=%0d required 5 0", n_acc, sb4.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        v8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b0;
        v4 = 1'b0; a4 = '0; b4 = '0; or4 = 1'b0;
`ifdef SIGNED_MULT_EN
        s4 = 1'b0;
`endif
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid();
        test_signed();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
